// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter for N requesters: MSB-first search from a rotating start point,
// registered one-hot grant held until done or a MAX_HOLD-cycle timeout.
module rr_priority_arbiter #(
    parameter int N        = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout
);

    localparam int HCW = $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [HCW-1:0] HOLD_SAT  = {HCW{1'b1}};

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [HCW-1:0] hold_cnt;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           found;

    // Walk ptr, ptr-1, ... modulo N; IDW-bit subtraction provides the wrap.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = ptr - IDW'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= IDW'(N - 1);
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (found) begin
                        gnt       <= {{(N-1){1'b0}}, 1'b1} << win;
                        gnt_id    <= win;
                        gnt_valid <= 1'b1;
                        ptr       <= win - IDW'(1);
                        hold_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (hold_cnt != HOLD_SAT)
                        hold_cnt <= hold_cnt + HCW'(1);
                    // done wins over a coincident timeout, so no pulse in that case
                    if (done || hold_cnt == HOLD_LAST) begin
                        gnt       <= '0;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                        timeout   <= !done;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Scoreboard bench for rr_priority_arbiter: stimulus queues expected grants/releases,
// a negedge monitor pops and compares as the DUT presents them.
module tb_rr_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    typedef struct {
        bit exp_to;
        int len;
    } rel_t;

    int   gq[$];
    rel_t rq[$];
    int   checks = 0;
    int   passes = 0;

    rr_priority_arbiter #(.N(8), .IDW(3), .MAX_HOLD(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One arbitration: req is presented for one edge, then dropped (the grant must hold).
    task automatic run_grant(input logic [7:0] r, input int id, input int len,
                             input bit use_done, input bit exp_to);
        rel_t e;
        req = r;
        gq.push_back(id);
        tick();
        req = 8'h00;
        e.exp_to = exp_to;
        e.len    = len;
        rq.push_back(e);
        if (use_done) begin
            repeat (len - 1) tick();
            done = 1'b1;
            tick();
            done = 1'b0;
        end else begin
            repeat (len) tick();
        end
    endtask

    // Monitor
    logic       pv = 1'b0;
    logic [7:0] pg = '0;
    int         hlen = 0;
    always @(negedge clk) begin
        int   e;
        rel_t r;
        if (!rst_n) begin
            pv   = 1'b0;
            pg   = '0;
            hlen = 0;
        end else begin
            check("valid_eq_or", int'(gnt_valid), int'(|gnt));
            check("onehot", int'($countones(gnt) <= 1), 1);
            if (!gnt_valid) check("id_idle", int'(gnt_id), 0);
            if (gnt_valid && !pv) begin
                if (gq.size() == 0) check("unexpected_gnt", 1, 0);
                else begin
                    e = gq.pop_front();
                    check("gnt_id", int'(gnt_id), e);
                    check("gnt_vec", int'(gnt), 1 << e);
                end
                hlen = 1;
            end else if (gnt_valid) begin
                check("gnt_stable", int'(gnt), int'(pg));
                hlen++;
            end
            if (!gnt_valid && pv) begin
                if (rq.size() == 0) check("unexpected_release", 1, 0);
                else begin
                    r = rq.pop_front();
                    check("timeout", int'(timeout), int'(r.exp_to));
                    check("hold_len", hlen, r.len);
                end
            end else begin
                check("timeout_quiet", int'(timeout), 0);
            end
            pv = gnt_valid;
            pg = gnt;
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;
        done  = 1'b0;
        repeat (2) tick();
        check("rst_gnt", int'(gnt), 0);
        check("rst_gnt_id", int'(gnt_id), 0);
        check("rst_valid", int'(gnt_valid), 0);
        check("rst_timeout", int'(timeout), 0);
        rst_n = 1'b1;

        // Rotation with all requesting: 7..0 then wrap to 7 (ptr ends at 6)
        for (int i = 0; i < 9; i++)
            run_grant(8'hFF, (7 - i + 8) % 8, 1, 1'b1, 1'b0);
        run_grant(8'h01, 0, 2, 1'b1, 1'b0);        // ptr -> 7
        run_grant(8'h03, 1, 1, 1'b1, 1'b0);        // ptr -> 0
        run_grant(8'h04, 2, 3, 1'b1, 1'b0);        // ptr -> 1
        run_grant(8'h82, 1, 1, 1'b1, 1'b0);        // 1 beats 7; ptr -> 0
        run_grant(8'h08, 3, 16, 1'b0, 1'b1);       // forced release; ptr -> 2
        run_grant(8'h0C, 2, 1, 1'b1, 1'b0);        // proves ptr was 2; ptr -> 1
        run_grant(8'h10, 4, 16, 1'b1, 1'b0);       // done on last hold cycle; ptr -> 3

        // Async reset in the middle of a grant
        req = 8'h20;
        gq.push_back(5);
        tick();
        req = 8'h00;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_gnt", int'(gnt), 0);
        check("async_gnt_id", int'(gnt_id), 0);
        check("async_valid", int'(gnt_valid), 0);
        check("async_timeout", int'(timeout), 0);
        tick();
        tick();
        rst_n = 1'b1;
        run_grant(8'h81, 7, 1, 1'b1, 1'b0);        // ptr back at 7
        run_grant(8'h01, 0, 1, 1'b1, 1'b0);
        repeat (3) tick();

        check("gq_drained", gq.size(), 0);
        check("rq_drained", rq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rr_priority_arbiter.md
# rr_priority_arbiter

Sequential round-robin arbiter that shares one resource among 8 requesters. Internally it uses the same MSB-first priority-encoding rule as the team's 8-to-3 priority encoder, but the search start point rotates after every grant. It issues a registered one-hot grant plus a 3-bit index and holds the grant until the owner signals `done` or a hold timeout expires. It sits between the request sources and the shared datapath, and sequences access so that no requester starves.

## Interface
- `N`, default 8: number of requesters. Fixed at 8 for this revision.
- `IDW`, default 3: index width, equal to log2(N).
- `MAX_HOLD`, default 16: maximum number of cycles a grant may be held. Legal range 2..255.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, N: request vector. Bit i high means requester i wants the resource.
- `done`, input, 1: release pulse from the current owner. Sampled only in GRANT.
- `gnt`, output, N: registered one-hot grant. All zeros when idle.
- `gnt_id`, output, IDW: registered index of the granted requester.
- `gnt_valid`, output, 1: high while a grant is active. Equals `|gnt`.
- `timeout`, output, 1: one-cycle pulse when a grant is forcibly revoked.

## Operation
States:
- IDLE (reset state).
- GRANT.

Registers:
- `ptr[IDW-1:0]`: search start point. Resets to N-1 (7).
- `hold_cnt`: width ceil(log2(MAX_HOLD+1)). Resets to 0.

Arbitration (combinational, evaluated in IDLE):
- Search order is `ptr`, `ptr-1`, …, 0, N-1, …, `ptr+1`, all modulo N.
- The first set bit of `req` in that order wins.
- At reset this is plain MSB-first priority (bit 7 highest).

IDLE behaviour:
- `req == 0`: stay in IDLE; all outputs 0.
- `req != 0`: on the next edge, load `gnt` with one-hot(winner), `gnt_id` with winner, set `gnt_valid`.
- On the same edge, set `ptr` to `(winner-1) mod N` (0 wraps to 7), clear `hold_cnt`, and go to GRANT.

GRANT behaviour:
- `hold_cnt` increments every cycle, saturating.
- `req` is ignored in this state. A grant is held even if the owner's `req` bit drops.
- `done == 1`: on the next edge, clear `gnt`, `gnt_id` and `gnt_valid`, and go to IDLE. No timeout pulse.
- `done == 0` and `hold_cnt == MAX_HOLD-1`: forced release on the next edge (same clears as `done`). `timeout` is 1 for exactly that next cycle. `ptr` is already advanced, so the offender loses priority.
- `done` and the timeout condition in the same cycle: treat as a normal `done`. `timeout` stays 0.

Other rules:
- `gnt_id` holds 0 whenever `gnt_valid` is 0.
- Only one bit of `gnt` is ever set.
- Reset mid-grant clears everything immediately and asynchronously: `gnt=0`, `gnt_id=0`, `gnt_valid=0`, `timeout=0`, `ptr=7`, `hold_cnt=0`, state IDLE.

## Timing
- Reset values of all outputs are 0. `ptr=7`.
- Grant latency: `req` sampled at edge k in IDLE gives `gnt` valid after edge k.
- Release latency: `done` high at edge k gives `gnt=0` after edge k.
- The earliest re-arbitration is at edge k+1, so back-to-back grants are separated by exactly one idle cycle.
- Maximum grant duration is MAX_HOLD cycles (`gnt_valid` high for cycles 0..MAX_HOLD-1). The release edge follows.
- `timeout` is coincident with the first idle cycle after a forced release.
- No combinational path from any input to any output.

## Test plan
- Reset with `req=8'hFF`, then release `rst_n`: `gnt=8'h80`, `gnt_id=7` one cycle later.
- `req=8'hFF` held, `done` pulsed one cycle after each grant: grant sequence 7,6,5,4,3,2,1,0,7 with one idle cycle between grants.
- Ptr wrap: after a grant to 0 (`ptr=7`), `req=8'b0000_0011` gives `gnt_id=1`. After a grant to 2 (`ptr=1`), `req=8'b1000_0010` gives `gnt_id=1`, not 7.
- Timeout: MAX_HOLD=16, `req=8'h08` granted, `done` never asserted. `gnt_valid` stays high for 16 cycles, then drops. `timeout=1` for one cycle and `ptr=2`.
- Simultaneous `done` and last hold cycle: release occurs, `timeout` stays 0. Dropping the owner's `req` mid-grant leaves `gnt` unchanged.
- Assert `rst_n=0` asynchronously mid-grant (between edges): all outputs go to 0 immediately. After release with `req=8'h01`, `gnt_id=0` (`ptr` back at 7).
